// File: rtl/audio_mem_pkg.sv
// Shared definitions for the audio sample-memory arbiter: FSM encodings,
// default address/data widths and a small sizing helper.
package audio_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RETURN = 2'd3
  } arb_state_t;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 16;

  // Latency counter width; a latency of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int rd_lat);
    return (rd_lat > 1) ? $clog2(rd_lat) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot round-robin selector: the first requesting slot
// after last_grant (with wrap) wins.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant
);

  // Scan N slots starting at last_grant+1; found_v blocks later hits.
  always_comb begin
    int             pos_v;
    logic [IDW-1:0] idx_v;
    logic           found_v;
    logic           hit_v;
    grant   = '0;
    found_v = 1'b0;
    pos_v   = 0;
    idx_v   = '0;
    hit_v   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos_v        = int'(last_grant) + k;
      pos_v        = (pos_v >= N) ? (pos_v - N) : pos_v;
      idx_v        = pos_v[IDW-1:0];
      hit_v        = req[idx_v] & ~found_v;
      grant[idx_v] = grant[idx_v] | hit_v;
      found_v      = found_v | hit_v;
    end
  end

endmodule

// File: rtl/audio_mem_arbiter.sv
// Round-robin arbiter for the single audio sample-memory read port, one read
// in flight. Define AUDIO_ARB_PRIO0_EN to give requester 0 strict priority.
module audio_mem_arbiter
  import audio_mem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(RD_LAT);

  arb_state_t          state_r;
  arb_state_t          next_state_s;
  logic [IDW-1:0]      last_grant_r;
  logic [IDW-1:0]      id_r;
  logic [IDW-1:0]      win_id_s;
  logic [CNT_W-1:0]    wait_cnt_r;
  logic [NUM_REQ-1:0]  rr_req_s;
  logic [NUM_REQ-1:0]  rr_grant_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [NUM_REQ-1:0]  req_ready_s;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                mem_rd_en_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [ADDR_W-1:0]   win_addr_s;
  logic                any_req_s;
  logic                wait_done_s;

`ifdef AUDIO_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the others rotate among themselves.
  assign rr_req_s = req_valid & ~{{(NUM_REQ-1){1'b0}}, 1'b1};
  assign grant_s  = req_valid[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : rr_grant_s;
`else
  assign rr_req_s = req_valid;
  assign grant_s  = rr_grant_s;
`endif

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_pick (
    .req        (rr_req_s),
    .last_grant (last_grant_r),
    .grant      (rr_grant_s)
  );

  assign any_req_s   = |grant_s;
  assign wait_done_s = (wait_cnt_r == CNT_W'(RD_LAT - 1));

  // Encode the one-hot winner into an id and select its address.
  always_comb begin
    win_addr_s = '0;
    win_id_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_addr_s = win_addr_s | ({ADDR_W{grant_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
      win_id_s   = win_id_s | (grant_s[i] ? IDW'(i) : IDW'(0));
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ARB_IDLE:   next_state_s = any_req_s ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE:  next_state_s = ARB_WAIT;
      ARB_WAIT:   next_state_s = wait_done_s ? ARB_RETURN : ARB_WAIT;
      ARB_RETURN: next_state_s = ARB_IDLE;
      default:    next_state_s = ARB_IDLE;
    endcase
  end

  // FSM combinational output: accept pulse only while idle and out of reset.
  always_comb begin
    req_ready_s = '0;
    case (state_r)
      ARB_IDLE: req_ready_s = reset ? '0 : grant_s;
      default:  req_ready_s = '0;
    endcase
  end

  // Datapath: latch the accepted request, time the read, return the word.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_r <= IDW'(NUM_REQ - 1);
      id_r         <= '0;
      wait_cnt_r   <= '0;
      mem_rd_en_r  <= 1'b0;
      mem_addr_r   <= '0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
    end else begin
      mem_rd_en_r <= (next_state_s == ARB_ISSUE);
      rsp_valid_r <= (state_r == ARB_WAIT && wait_done_s) ?
                     ({{(NUM_REQ-1){1'b0}}, 1'b1} << id_r) : '0;
      case (state_r)
        ARB_IDLE: begin
          wait_cnt_r <= '0;
          if (any_req_s) begin
            id_r       <= win_id_s;
            mem_addr_r <= win_addr_s;
          end
        end
        ARB_WAIT: begin
          if (wait_done_s) begin
            rsp_data_r <= mem_rd_data;
            wait_cnt_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        ARB_RETURN: begin
`ifdef AUDIO_ARB_PRIO0_EN
          if (id_r != IDW'(0)) begin
            last_grant_r <= id_r;
          end
`else
          last_grant_r <= id_r;
`endif
        end
        default: begin
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign mem_rd_en = mem_rd_en_r;
  assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Directed self-checking bench for audio_mem_arbiter (NUM_REQ=4, RD_LAT=2);
// the RAM model returns addr[15:0] ^ 16'hA5A5 two cycles after the strobe.
module tb_audio_mem_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 21;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_rd_data;

  logic [DW-1:0]    ram_s1;
  logic [DW-1:0]    ram_s2;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] addr_tab[4] = '{21'h00010, 21'h12345, 21'h0ABCD, 21'h1FFFF};
  logic [DW-1:0] data_tab[4] = '{16'hA5B5, 16'h86E0, 16'h0E68, 16'h5A5A};

  audio_mem_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RD_LAT  (LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clock = ~clock;

  // Two-stage RAM model; non-strobe cycles feed a marker value.
  always @(posedge clock) begin
    ram_s1 <= mem_rd_en ? (mem_addr[15:0] ^ 16'hA5A5) : 16'hDEAD;
    ram_s2 <= ram_s1;
  end
  assign mem_rd_data = ram_s2;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic set_addrs();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = addr_tab[i];
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_accept(output logic [NR-1:0] got, output int n);
    n = 0;
    #1;
    while (req_ready === 4'b0000 && n < 20) begin
      cyc();
      #1;
      n++;
    end
    got = req_ready;
  endtask

  task automatic wait_rsp(input logic [NR-1:0] drop, output logic [NR-1:0] got, output int n);
    cyc();
    req_valid = req_valid & ~drop;
    #1;
    n = 1;
    while (rsp_valid === 4'b0000 && n < 20) begin
      cyc();
      #1;
      n++;
    end
    got = rsp_valid;
  endtask

  task automatic test_reset();
    req_addr = '0;
    do_reset();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en: got %b want 0", mem_rd_en); end
    checks++; if (mem_addr !== 21'h000000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_single();
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 21'h00100;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b want 0010", req_ready); end
    cyc(); req_valid = 4'b0000; #1;
    checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %b want 1", mem_rd_en); end
    checks++; if (mem_addr !== 21'h00100) begin errors++; $display("FAIL single_addr: got %h want 00100", mem_addr); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_busy: got %b want 0000", req_ready); end
    cyc(); #1;
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en_pulse: got %b want 0", mem_rd_en); end
    cyc(); #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early: got %b want 0000", rsp_valid); end
    cyc(); #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
    checks++; if (rsp_data !== 16'hA4A5) begin errors++; $display("FAIL single_rsp_data: got %h want a4a5", rsp_data); end
    cyc(); #1;
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse: got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 16'hA4A5) begin errors++; $display("FAIL single_rsp_hold: got %h want a4a5", rsp_data); end
  endtask

  task automatic test_all_four();
    logic [NR-1:0] got;
    int n;
`ifdef AUDIO_ARB_PRIO0_EN
    int exp_id[6] = '{0, 0, 0, 0, 0, 0};
`else
    int exp_id[6] = '{0, 1, 2, 3, 0, 1};
`endif
    set_addrs();
    do_reset();
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      wait_accept(got, n);
      checks++; if (got !== (4'b0001 << exp_id[g])) begin errors++; $display("FAIL rr4_grant%0d: got %b want id %0d", g, got, exp_id[g]); end
      if (g > 0) begin
        checks++; if (n !== 1) begin errors++; $display("FAIL rr4_gap%0d: got %0d cycles want 1", g, n); end
      end
      wait_rsp(4'b0000, got, n);
      checks++; if (got !== (4'b0001 << exp_id[g])) begin errors++; $display("FAIL rr4_rsp%0d: got %b want id %0d", g, got, exp_id[g]); end
      checks++; if (n !== 4) begin errors++; $display("FAIL rr4_latency%0d: got %0d want 4", g, n); end
      checks++; if (rsp_data !== data_tab[exp_id[g]]) begin errors++; $display("FAIL rr4_data%0d: got %h want %h", g, rsp_data, data_tab[exp_id[g]]); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_pair_rotation();
    logic [NR-1:0] got;
    int n;
    cyc(); cyc();
    req_valid = 4'b0100;
    wait_accept(got, n);
    checks++; if (got !== 4'b0100) begin errors++; $display("FAIL pair_setup: got %b want 0100", got); end
    wait_rsp(4'b0100, got, n);
    req_valid = 4'b1100;
    wait_accept(got, n);
    checks++; if (got !== 4'b1000) begin errors++; $display("FAIL pair_first: got %b want 1000", got); end
    wait_rsp(4'b1000, got, n);
    checks++; if (got !== 4'b1000 || rsp_data !== data_tab[3]) begin errors++; $display("FAIL pair_rsp3: got %b/%h want 1000/%h", got, rsp_data, data_tab[3]); end
    wait_accept(got, n);
    checks++; if (got !== 4'b0100) begin errors++; $display("FAIL pair_second: got %b want 0100", got); end
    wait_rsp(4'b0100, got, n);
    checks++; if (got !== 4'b0100 || rsp_data !== data_tab[2]) begin errors++; $display("FAIL pair_rsp2: got %b/%h want 0100/%h", got, rsp_data, data_tab[2]); end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] got;
    logic bad;
    int n;
    cyc(); cyc();
    req_valid = 4'b0010;
    wait_accept(got, n);
    checks++; if (got !== 4'b0010) begin errors++; $display("FAIL midrst_accept: got %b want 0010", got); end
    cyc(); req_valid = 4'b0000;
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      bad = bad | (rsp_valid !== 4'b0000) | (mem_rd_en !== 1'b0);
      cyc();
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midrst_quiet: got activity %b want 0", bad); end
    req_valid = 4'b0101;
    wait_accept(got, n);
    checks++; if (got !== 4'b0001) begin errors++; $display("FAIL midrst_prio: got %b want 0001", got); end
    wait_rsp(4'b0001, got, n);
    checks++; if (got !== 4'b0001 || rsp_data !== data_tab[0]) begin errors++; $display("FAIL midrst_rsp0: got %b/%h want 0001/%h", got, rsp_data, data_tab[0]); end
    wait_accept(got, n);
    checks++; if (got !== 4'b0100) begin errors++; $display("FAIL midrst_next: got %b want 0100", got); end
    wait_rsp(4'b0100, got, n);
    checks++; if (got !== 4'b0100 || rsp_data !== data_tab[2]) begin errors++; $display("FAIL midrst_rsp2: got %b/%h want 0100/%h", got, rsp_data, data_tab[2]); end
  endtask

  task automatic test_withdraw();
    logic [NR-1:0] got;
    logic [NR-1:0] rsp_at4;
    logic seen;
    int n;
    cyc(); cyc();
    req_valid = 4'b0001;
    wait_accept(got, n);
    checks++; if (got !== 4'b0001) begin errors++; $display("FAIL withdraw_accept0: got %b want 0001", got); end
    seen    = 1'b0;
    rsp_at4 = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (k == 1) req_valid = 4'b0010;
      if (k == 3) req_valid = 4'b0000;
      #1;
      seen = seen | req_ready[1];
      if (k == 4) rsp_at4 = rsp_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL withdraw_ready1: got %b want 0", seen); end
    checks++; if (rsp_at4 !== 4'b0001) begin errors++; $display("FAIL withdraw_rsp0: got %b want 0001", rsp_at4); end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] got;
    int n;
`ifdef AUDIO_ARB_PRIO0_EN
    int exp_id[4] = '{0, 0, 0, 0};
`else
    int exp_id[4] = '{0, 1, 0, 1};
`endif
    do_reset();
    req_valid = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      wait_accept(got, n);
      checks++; if (got !== (4'b0001 << exp_id[g])) begin errors++; $display("FAIL b2b_grant%0d: got %b want id %0d", g, got, exp_id[g]); end
      wait_rsp(4'b0000, got, n);
      checks++; if (got !== (4'b0001 << exp_id[g]) || rsp_data !== data_tab[exp_id[g]]) begin errors++; $display("FAIL b2b_rsp%0d: got %b/%h want id %0d/%h", g, got, rsp_data, exp_id[g], data_tab[exp_id[g]]); end
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    test_reset();
    test_single();
    test_all_four();
    test_pair_rotation();
    test_reset_mid();
    test_withdraw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
